// File: rtl/peri_bus_bridge_if.sv
// Bundle of the pipeline-side request/response signals and the peripheral
// req/ack bus handled by peri_bus_bridge.
// master : the bridge itself (it masters the peripheral bus).
// slave  : the surrounding environment (memory stage + peripheral).
interface peri_bus_bridge_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic        is_peri;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        bus_err;
    logic        p_req;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_be;
    logic        p_ack;
    logic [31:0] p_rdata;

    modport master (
        input  req_valid, req_we, req_addr, is_peri, req_wdata, req_be,
        input  p_ack, p_rdata,
        output stall, resp_valid, resp_rdata, bus_err,
        output p_req, p_we, p_addr, p_wdata, p_be
    );

    modport slave (
        output req_valid, req_we, req_addr, is_peri, req_wdata, req_be,
        output p_ack, p_rdata,
        input  stall, resp_valid, resp_rdata, bus_err,
        input  p_req, p_we, p_addr, p_wdata, p_be
    );
endinterface

// File: rtl/peri_bus_bridge.sv
// Peripheral bus bridge: turns a memory-stage access flagged as peripheral
// into a single req/ack transaction, stalling the pipeline until the
// peripheral acknowledges or the timeout counter expires.
module peri_bus_bridge #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input logic               clk,
    input logic               rst_n,
    peri_bus_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Value of the counter in the last cycle p_req may stay high unanswered.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  count_r;
    logic        p_req_r;
    logic        p_we_r;
    logic [31:0] p_addr_r;
    logic [31:0] p_wdata_r;
    logic [3:0]  p_be_r;
    logic [31:0] resp_rdata_r;
    logic        resp_valid_r;
    logic        bus_err_r;
    logic        stall_s;

    // Transaction FSM: latches the request, waits for ack or timeout, issues the response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            count_r      <= 8'd0;
            p_req_r      <= 1'b0;
            p_we_r       <= 1'b0;
            p_addr_r     <= 32'd0;
            p_wdata_r    <= 32'd0;
            p_be_r       <= 4'd0;
            resp_rdata_r <= 32'd0;
            resp_valid_r <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            // Response flags are single-cycle pulses unless set below.
            resp_valid_r <= 1'b0;
            bus_err_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && bus.is_peri) begin
                        p_we_r    <= bus.req_we;
                        // Word-align: the low address bits are dropped, not checked.
                        p_addr_r  <= bus.req_addr & 32'hFFFF_FFFC;
                        p_wdata_r <= bus.req_wdata;
                        p_be_r    <= bus.req_be;
                        p_req_r   <= 1'b1;
                        count_r   <= 8'd0;
                        state_r   <= BUSY;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                BUSY: begin
                    count_r <= count_r + 8'd1;
                    // An ack in the final timeout cycle still counts as success.
                    if (bus.p_ack) begin
                        p_req_r      <= 1'b0;
                        resp_rdata_r <= p_we_r ? 32'd0 : bus.p_rdata;
                        resp_valid_r <= 1'b1;
                        bus_err_r    <= 1'b0;
                        state_r      <= DONE;
                    end else if (count_r == TIMEOUT_LAST) begin
                        p_req_r      <= 1'b0;
                        resp_rdata_r <= p_we_r ? 32'd0 : ERR_DATA;
                        resp_valid_r <= 1'b1;
                        bus_err_r    <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        state_r      <= BUSY;
                    end
                end
                DONE: begin
                    // Pipeline advances here; a new request is only taken from IDLE.
                    state_r <= IDLE;
                end
                default: begin
                    p_req_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Stall from the moment a peripheral access is presented until the response cycle.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid && bus.is_peri) begin
                    stall_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            BUSY:    stall_s = 1'b1;
            DONE:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    assign bus.stall      = stall_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.bus_err    = bus_err_r;
    assign bus.p_req      = p_req_r;
    assign bus.p_we       = p_we_r;
    assign bus.p_addr     = p_addr_r;
    assign bus.p_wdata    = p_wdata_r;
    assign bus.p_be       = p_be_r;

endmodule
